// File: rtl/grf_bypass_pkg.sv
// Shared constants for the general register file: geometry, the hardwired zero
// register index and the retire-counter reset value.
package grf_bypass_pkg;

    localparam int GRF_DW       = 32;
    localparam int GRF_AW       = 5;
    localparam int GRF_ZERO_REG = 0;

    localparam logic [31:0] GRF_WR_COUNT_RST = 32'h0000_0000;

endpackage : grf_bypass_pkg

// File: rtl/grf_bypass_read_port.sv
// One combinational register-file read port with optional same-cycle
// write-through from the W stage; address 0 always reads as zero.
module grf_bypass_read_port
    import grf_bypass_pkg::*;
#(
    parameter int DW     = GRF_DW,
    parameter int AW     = GRF_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic [AW-1:0]                addr,
    input  logic [(2**AW)-1:0][DW-1:0]   regs,
    input  logic                         eff_wr,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DW-1:0]                wr_data,
    output logic [DW-1:0]                data
);

    // Read mux: zero register first, then bypass, then committed storage.
    always_comb begin
        data = '0;
        if (addr == AW'(GRF_ZERO_REG)) begin
            data = '0;
        end else if (BYPASS && eff_wr && (wr_addr == addr)) begin
            data = wr_data;
        end else begin
            data = regs[addr];
        end
    end

endmodule : grf_bypass_read_port

// File: rtl/grf_bypass.sv
// General register file fed by the W-stage write interface, with two bypassed
// D-stage read ports, a committed-state debug port and a retire trace record.
module grf_bypass
    import grf_bypass_pkg::*;
#(
    parameter int DW     = GRF_DW,
    parameter int AW     = GRF_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    input  logic [AW-1:0] A3,
    input  logic [DW-1:0] WD,
    input  logic          RFWr,
    input  logic [31:0]   PC,
    input  logic [AW-1:0] Dbg_A,
    output logic [DW-1:0] Dbg_RD,
    output logic [31:0]   Wr_Count,
    output logic [AW-1:0] Last_A3,
    output logic [DW-1:0] Last_WD,
    output logic [31:0]   Last_PC,
    output logic          Last_Valid
);

    localparam int NREG = 2**AW;

    logic [NREG-1:0][DW-1:0] regs_r;
    logic [31:0]             wr_count_r;
    logic [AW-1:0]           last_a3_r;
    logic [DW-1:0]           last_wd_r;
    logic [31:0]             last_pc_r;
    logic                    last_valid_r;
    logic                    eff_wr_s;

    // Writes to the zero register are dropped entirely; RFWr gates A3 so X on an idle bus is harmless.
    always_comb begin
        eff_wr_s = 1'b0;
        if (RFWr) begin
            eff_wr_s = (A3 != AW'(GRF_ZERO_REG));
        end else begin
            eff_wr_s = 1'b0;
        end
    end

    // Register storage; entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            regs_r <= '0;
        end else if (eff_wr_s) begin
            regs_r[A3] <= WD;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Retire counter and last-write trace record, updated only on effective writes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_count_r   <= GRF_WR_COUNT_RST;
            last_a3_r    <= '0;
            last_wd_r    <= '0;
            last_pc_r    <= 32'h0000_0000;
            last_valid_r <= 1'b0;
        end else if (eff_wr_s) begin
            wr_count_r   <= wr_count_r + 32'd1;
            last_a3_r    <= A3;
            last_wd_r    <= WD;
            last_pc_r    <= PC;
            last_valid_r <= 1'b1;
        end else begin
            wr_count_r   <= wr_count_r;
            last_a3_r    <= last_a3_r;
            last_wd_r    <= last_wd_r;
            last_pc_r    <= last_pc_r;
            last_valid_r <= last_valid_r;
        end
    end

    grf_bypass_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd1 (
        .addr    (A1),
        .regs    (regs_r),
        .eff_wr  (eff_wr_s),
        .wr_addr (A3),
        .wr_data (WD),
        .data    (RD1)
    );

    grf_bypass_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd2 (
        .addr    (A2),
        .regs    (regs_r),
        .eff_wr  (eff_wr_s),
        .wr_addr (A3),
        .wr_data (WD),
        .data    (RD2)
    );

    // The debug port shows committed state only, so its bypass is always off.
    grf_bypass_read_port #(.DW(DW), .AW(AW), .BYPASS(1'b0)) u_dbg (
        .addr    (Dbg_A),
        .regs    (regs_r),
        .eff_wr  (eff_wr_s),
        .wr_addr (A3),
        .wr_data (WD),
        .data    (Dbg_RD)
    );

    assign Wr_Count   = wr_count_r;
    assign Last_A3    = last_a3_r;
    assign Last_WD    = last_wd_r;
    assign Last_PC    = last_pc_r;
    assign Last_Valid = last_valid_r;

endmodule : grf_bypass

// File: doc/grf_bypass.md
Name: grf_bypass

Overview:
- General register file at the receiving end of the W-stage write interface (A3 / WD / RFWr).
- Provides two combinational read ports to the D stage, with write-through bypass, so a same-cycle W write is visible to D reads without a stall.
- $0 is hardwired to zero.
- Also keeps debug/retire state: an effective-write counter and a last-write record for the trace checker.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width; register count is 2**AW.
- BYPASS, 1, 1 = write-through bypass on read ports; 0 = reads return stored value only.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- A1  input  AW  read port 1 address (rs).
- A2  input  AW  read port 2 address (rt).
- RD1  output  DW  read port 1 data.
- RD2  output  DW  read port 2 data.
- A3  input  AW  write address from W stage.
- WD  input  DW  write data from W stage.
- RFWr  input  1  write enable from W stage.
- PC  input  32  PC of the W-stage instruction, logging only.
- Dbg_A  input  AW  debug read address.
- Dbg_RD  output  DW  debug read data; no bypass.
- Wr_Count  output  32  number of effective writes since reset.
- Last_A3  output  AW  address of most recent effective write.
- Last_WD  output  DW  data of most recent effective write.
- Last_PC  output  32  PC of most recent effective write.
- Last_Valid  output  1  at least one effective write since reset.

Behaviour:
- Reset is asynchronous and active-high: asserting Rst immediately forces all registers, Wr_Count, Last_A3, Last_WD, Last_PC and Last_Valid to 0, regardless of Clk.
- Deassertion is sampled by the next rising edge. Rst mid-stream discards any write in that cycle.
- Effective write: eff_wr = RFWr && (A3 != 0).
  - On a rising edge with eff_wr and Rst low: reg[A3] <= WD; Wr_Count <= Wr_Count + 1 (wraps modulo 2**32, no saturation); Last_A3/WD/PC <= A3/WD/PC; Last_Valid <= 1.
  - RFWr with A3 == 0: no state change at all; counter and Last_* hold.
- Reads are combinational, zero latency:
  - RDn = 0 if An == 0.
  - Else, if BYPASS && eff_wr && A3 == An, RDn = WD (same-cycle bypass).
  - Else RDn = reg[An].
- Both read ports may bypass simultaneously when A1 == A2 == A3.
- Dbg_RD = reg[Dbg_A], or 0 for address 0. Never bypassed; it reflects committed state only.
- reg[0] is never written. An implementation may omit its storage, but it must always read 0.
- Two writes to the same address on consecutive edges: the later edge wins; Wr_Count increments twice.
- Outputs are glitch-tolerant combinational logic. No outputs are registered except the counter and the Last_* fields.
- X on A3/WD while RFWr = 0 must not corrupt state.

Decomposition:
- Shared constants file (existing const include) gains:
  - GRF_DW, GRF_AW.
  - GRF_ZERO_REG = 0.
  - The reset value for Wr_Count.
- One sub-module is natural: grf_read_port (address, storage vector, eff_wr, A3, WD, BYPASS → data).
  - Instantiated twice for RD1/RD2.
  - Instantiated a third time with bypass disabled for Dbg_RD.
- Counter and last-write record stay inline.

Test Plan:
- Reset: pulse Rst mid-cycle (not on an edge) after writing reg 5 = 0x1234 → RD of 5 reads 0 immediately; Wr_Count = 0; Last_Valid = 0.
- Basic write/read: RFWr=1, A3=8, WD=0xDEADBEEF, one edge; then A1=8 → RD1 = 0xDEADBEEF; Wr_Count = 1; Last_A3 = 8; Last_PC equals the PC driven.
- Bypass: before the edge, A1=A2=A3=9, WD=0xCAFE0001, RFWr=1 → RD1 = RD2 = 0xCAFE0001 in the same cycle while Dbg_RD(9) = old value 0. With BYPASS=0 → RD1 = 0.
- $0 protection: RFWr=1, A3=0, WD=0xFFFFFFFF, edge → RD1(A1=0) = 0; Wr_Count unchanged; Last_* unchanged.
- Back-to-back: write r31 = 0x3000 then r31 = 0x3004 on consecutive edges → RD1 = 0x3004; Wr_Count increases by 2.
- Counter wrap: force/preload Wr_Count = 0xFFFFFFFF, one effective write → Wr_Count = 0; Last_Valid stays 1.
